boa_pmu_ctl: RTL and testbench

// - Responder end of the CPU power-management interface: services reset/shutdown requests raised by the core.
// - Debounces the board reset button, holds CPU reset for a fixed time, drains before shutdown, gates the CPU clock.
// - Sits in the FPGA top between the raw board I/O and main; replaces the ad-hoc rst/shdn flops there.

---
 rtl/boa_pmu_pkg.sv | 30 +++
 rtl/boa_pmu_if.sv | 16 +
 rtl/boa_debounce.sv | 59 +++++
 rtl/boa_pmu_ctl.sv | 141 ++++++++++++++
 tb/tb_boa_pmu_ctl.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boa_pmu_pkg.sv
// boa_pmu_pkg: PMU state encoding shared with LED/debug decode,
// plus width helpers for the hold/drain and debounce counters.
package boa_pmu_pkg;

  localparam logic [1:0] PMU_ENC_RESET = 2'd0;
  localparam logic [1:0] PMU_ENC_RUN   = 2'd1;
  localparam logic [1:0] PMU_ENC_DRAIN = 2'd2;
  localparam logic [1:0] PMU_ENC_OFF   = 2'd3;

  typedef enum logic [1:0] {
    PMU_RESET = PMU_ENC_RESET,
    PMU_RUN   = PMU_ENC_RUN,
    PMU_DRAIN = PMU_ENC_DRAIN,
    PMU_OFF   = PMU_ENC_OFF
  } pmu_state_t;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boa_pmu_if.sv
// boa_pmu_if: core-to-PMU request bus (reset and shutdown levels).
// The core is the master; the PMU controller is the slave.
interface boa_pmu_if;
  logic rst_req;
  logic shdn_req;

  modport master (
    output rst_req,
    output shdn_req
  );

  modport slave (
    input rst_req,
    input shdn_req
  );
endinterface

// File: rtl/boa_debounce.sv
// boa_debounce: 2-flop synchroniser, stability counter and
// registered rising-edge pulse for one raw button input.
module boa_debounce
  import boa_pmu_pkg::*;
#(
  parameter int unsigned CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = cnt_w(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // count consecutive samples that disagree with the accepted level
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/boa_pmu_ctl.sv
// boa_pmu_ctl: CPU reset/shutdown/clock-gate sequencer.
// Optional BOA_PMU_WAKE_EN adds a wake button that resumes from OFF.
module boa_pmu_ctl
  import boa_pmu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned DRAIN_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  boa_pmu_if.slave   pmu_bus,
  input  logic       btn_rst,
  input  logic       btn_wake,
  output logic       cpu_rst,
  output logic       clk_en,
  output logic [1:0] pmu_state
);

  localparam int unsigned MAXC =
    max_u(RST_HOLD_CYCLES, DRAIN_CYCLES);
  localparam int unsigned CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST =
    CNT_W'(DRAIN_CYCLES);

  pmu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             clk_en_q, clk_en_d;
  logic [1:0]       pst_q, pst_d;

  logic rst_lvl;
  logic rst_press;
  logic wake_press;
  logic rst_evt;

  boa_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_rst),
    .level_o (rst_lvl),
    .press_o (rst_press)
  );

`ifdef BOA_PMU_WAKE_EN
  logic wake_level_unused;

  boa_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db_wake (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_wake),
    .level_o (wake_level_unused),
    .press_o (wake_press)
  );
`else
  logic unused_wake;
  assign unused_wake = btn_wake;
  assign wake_press  = 1'b0;
`endif

  assign rst_evt = pmu_bus.rst_req | rst_press;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PMU_RESET: begin
        // saturate at the hold limit so release can happen later
        if (cnt_q == HOLD_LAST) begin
          if (!rst_lvl && !pmu_bus.rst_req) begin
            state_d = PMU_RUN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PMU_RUN: begin
        if (rst_evt) begin
          state_d = PMU_RESET;
          cnt_d   = '0;
        end else if (pmu_bus.shdn_req) begin
          state_d = PMU_DRAIN;
          cnt_d   = '0;
        end
      end
      PMU_DRAIN: begin
        if (rst_evt) begin
          state_d = PMU_RESET;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = PMU_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PMU_OFF: begin
        // core requests are stale here: its clock is stopped
        if (rst_press) begin
          state_d = PMU_RESET;
          cnt_d   = '0;
        end else if (wake_press) begin
          state_d = PMU_RUN;
        end
      end
      default: begin
        state_d = PMU_RESET;
        cnt_d   = '0;
      end
    endcase
    cpu_rst_d = (state_d == PMU_RESET);
    clk_en_d  = (state_d != PMU_OFF);
    pst_d     = state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PMU_RESET;
      cnt_q     <= '0;
      cpu_rst_q <= 1'b1;
      clk_en_q  <= 1'b1;
      pst_q     <= PMU_ENC_RESET;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpu_rst_q <= cpu_rst_d;
      clk_en_q  <= clk_en_d;
      pst_q     <= pst_d;
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign clk_en    = clk_en_q;
  assign pmu_state = pst_q;

endmodule

// File: tb/tb_boa_pmu_ctl.sv
// tb_boa_pmu_ctl: scenario bench for the PMU sequencer
// (DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8, DRAIN_CYCLES=3).
module tb_boa_pmu_ctl;

  // expected {pmu_state, cpu_rst, clk_en}
  localparam logic [3:0] E_RST = 4'b0011;
  localparam logic [3:0] E_RUN = 4'b0101;
  localparam logic [3:0] E_DRN = 4'b1001;
  localparam logic [3:0] E_OFF = 4'b1100;

  typedef struct {
    logic       rr;
    logic       sd;
    logic       br;
    logic       bw;
    logic [3:0] exp;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_rst = 1'b0;
  logic       btn_wake = 1'b0;
  logic       cpu_rst;
  logic       clk_en;
  logic [1:0] pmu_state;

  int    errors = 0;
  int    checks = 0;
  step_t sb[$];

  boa_pmu_if bus ();

  boa_pmu_ctl #(
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD_CYCLES (8),
    .DRAIN_CYCLES    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pmu_bus   (bus),
    .btn_rst   (btn_rst),
    .btn_wake  (btn_wake),
    .cpu_rst   (cpu_rst),
    .clk_en    (clk_en),
    .pmu_state (pmu_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] obs();
    return {pmu_state, cpu_rst, clk_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rr, input logic sd,
                     input logic br, input logic bw,
                     input logic [3:0] e, input int n);
    step_t s;
    s.rr = rr; s.sd = sd; s.br = br; s.bw = bw; s.exp = e;
    repeat (n) sb.push_back(s);
  endtask

  task automatic test_reset();
    step_t s;
    int    k = 0;
    bus.rst_req = 1'b0;
    bus.shdn_req = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL rst_cpu_rst got=%b exp=1", cpu_rst);
    end
    checks++;
    if (clk_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_clk_en got=%b exp=1", clk_en);
    end
    checks++;
    if (pmu_state !== 2'd0) begin
      errors++;
      $display("FAIL rst_state got=%0d exp=0", pmu_state);
    end
    tick();
    rst_n = 1'b1;
    add(0, 0, 0, 0, E_RST, 7);
    add(0, 0, 0, 0, E_RUN, 2);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL reset_release step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
  endtask

  task automatic test_shutdown();
    step_t s;
    int    k = 0;
    add(0, 1, 0, 0, E_DRN, 1);
    add(0, 0, 0, 0, E_DRN, 3);
    add(0, 0, 0, 0, E_OFF, 2);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL shutdown step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
  endtask

  task automatic test_off_ignore();
    step_t s;
    int    k = 0;
    add(1, 0, 0, 0, E_OFF, 2);
    add(0, 1, 0, 0, E_OFF, 2);
    add(1, 1, 0, 0, E_OFF, 2);
    add(0, 0, 0, 0, E_OFF, 1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL off_ignore step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
  endtask

  task automatic test_wake();
`ifdef BOA_PMU_WAKE_EN
    int   t_run = -1;
    logic rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      btn_wake = (i < 10);
      tick();
      if (cpu_rst === 1'b1) rose = 1'b1;
      if (t_run < 0 && pmu_state === 2'd1) t_run = i;
    end
    checks++;
    if (t_run < 0) begin
      errors++;
      $display("FAIL wake_run got=none exp=RUN within 40 cycles");
    end
    checks++;
    if (rose !== 1'b0) begin
      errors++;
      $display("FAIL wake_cpu_rst got=%b exp=0", rose);
    end
    checks++;
    if (obs() !== E_RUN) begin
      errors++;
      $display("FAIL wake_final got=%b exp=%b", obs(), E_RUN);
    end
`else
    step_t s;
    int    k = 0;
    add(0, 0, 0, 1, E_OFF, 10);
    add(0, 0, 0, 0, E_OFF, 12);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL wake_disabled step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
`endif
  endtask

  task automatic test_btn_press(input string nm);
    int t_rst = -1;
    int t_run = -1;
    int n_rst = 0;
    int bad = 0;
    for (int i = 0; i < 60; i++) begin
      btn_rst = (i < 10);
      tick();
      if (pmu_state === 2'd0) begin
        n_rst++;
        if (t_rst < 0) t_rst = i;
        if (cpu_rst !== 1'b1 || clk_en !== 1'b1) bad++;
      end
      if (t_rst >= 0 && pmu_state === 2'd1) begin
        t_run = i;
        break;
      end
    end
    btn_rst = 1'b0;
    checks++;
    if (t_rst < 4 || t_rst > 10) begin
      errors++;
      $display("FAIL %s_enter got=%0d exp=4..10", nm, t_rst);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_outputs got=%0d bad cycles exp=0", nm, bad);
    end
    checks++;
    if (t_run < 15) begin
      errors++;
      $display("FAIL %s_release got=%0d exp>=15", nm, t_run);
    end
    checks++;
    if (n_rst < 8) begin
      errors++;
      $display("FAIL %s_hold got=%0d exp>=8", nm, n_rst);
    end
  endtask

  task automatic test_glitch();
    step_t s;
    int    k = 0;
    add(0, 0, 1, 0, E_RUN, 3);
    add(0, 0, 0, 0, E_RUN, 10);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL glitch step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
  endtask

  task automatic test_rst_shdn_same();
    step_t s;
    int    k = 0;
    add(1, 1, 0, 0, E_RST, 1);
    add(0, 0, 0, 0, E_RST, 7);
    add(0, 0, 0, 0, E_RUN, 2);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL rst_shdn_same step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
  endtask

  task automatic test_drain_abort();
    step_t s;
    int    k = 0;
    add(0, 1, 0, 0, E_DRN, 1);
    add(1, 0, 0, 0, E_RST, 1);
    add(0, 0, 0, 0, E_RST, 7);
    add(0, 0, 0, 0, E_RUN, 1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL drain_abort step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s;
    int    k = 0;
    add(0, 1, 0, 0, E_DRN, 1);
    add(0, 0, 0, 0, E_DRN, 1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL async_pre got=%b exp=%b", obs(), s.exp);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== E_RST) begin
      errors++;
      $display("FAIL async_assert got=%b exp=%b", obs(), E_RST);
    end
    tick();
    rst_n = 1'b1;
    add(0, 0, 0, 0, E_RST, 7);
    add(0, 0, 0, 0, E_RUN, 1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL async_release step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
  endtask

  task automatic test_shdn_through_reset();
    step_t s;
    int    k = 0;
    add(1, 1, 0, 0, E_RST, 1);
    add(0, 1, 0, 0, E_RST, 7);
    add(0, 1, 0, 0, E_RUN, 1);
    add(0, 1, 0, 0, E_DRN, 4);
    add(0, 0, 0, 0, E_OFF, 2);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      {bus.rst_req, bus.shdn_req, btn_rst, btn_wake} = {s.rr, s.sd, s.br, s.bw};
      tick();
      k++;
      checks++;
      if (obs() !== s.exp) begin
        errors++;
        $display("FAIL shdn_through_reset step %0d got=%b exp=%b", k, obs(), s.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shutdown();
    test_off_ignore();
    test_wake();
    test_btn_press("btn_from_off");
    test_glitch();
    test_btn_press("btn_from_run");
    test_rst_shdn_same();
    test_drain_abort();
    test_async_reset();
    test_shdn_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
